sram_req_arbiter: RTL and testbench
===================================

Name: sram_req_arbiter

Overview:
Merges the instruction-fetch like-SRAM port (read-only) and the data-memory like-SRAM port into one downstream like-SRAM port feeding the AXI bridge. The downstream side completes requests in issue order. A tag FIFO records which requester owns each outstanding transaction, so every data_ok and its rdata go back to the right stage. It sits between if_stage/exe_stage/mem_stage and the bridge.

Parameters:
DEPTH, 2, max outstanding downstream transactions (power of 2, ≥2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req  in  1  fetch request valid, held stable until inst_addr_ok
inst_size  in  2  fetch size (always 2'b10)
inst_addr  in  32  fetch physical address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch data returned this cycle
inst_rdata  out  32  fetch data
data_req  in  1  data request valid, held stable until data_addr_ok
data_wr  in  1  1 = write
data_size  in  2  0 = byte, 1 = half, 2 = word
data_wstrb  in  4  byte enables
data_addr  in  32  data physical address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  load data or write completion returned
data_rdata  out  32  load data
mem_req  out  1  downstream request
mem_wr  out  1  downstream write
mem_size  out  2  downstream size
mem_wstrb  out  4  downstream byte enables (0 for inst)
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream wdata (0 for inst)
mem_addr_ok  in  1  downstream accept
mem_data_ok  in  1  downstream completion, in issue order
mem_rdata  in  32  downstream read data

Behaviour:
- Tag FIFO: DEPTH entries, 1 bit each (0 = inst, 1 = data). Pointers are log2(DEPTH) bits and wrap. Count is log2(DEPTH)+1 bits.
- Grant is combinational, with fixed priority data > inst.
  - sel_data = data_req.
  - sel_inst = inst_req && !data_req.
  - Grant is enabled only when FIFO count < DEPTH.
- mem_req = (data_req || inst_req) && !full.
- mem_* fields mux from the selected source. Inst maps to wr = 0, wstrb = 0, wdata = 0.
- data_addr_ok = mem_addr_ok && mem_req && sel_data.
- inst_addr_ok = mem_addr_ok && mem_req && sel_inst.
- Push: on mem_req && mem_addr_ok, push the tag of the selected source.
- Pop: on mem_data_ok && !empty, pop the head.
  - data_data_ok = mem_data_ok && !empty && head.
  - inst_data_ok = mem_data_ok && !empty && !head.
  - inst_rdata and data_rdata both = mem_rdata, qualified only by their data_ok.
- Same-cycle push and pop: count unchanged, both pointers advance.
- Full: a same-cycle pop does NOT unblock grant; mem_req stays 0 that cycle. This avoids a combinational loop from mem_data_ok to mem_req.
- mem_data_ok while empty: ignored, no output pulses, count stays 0. This is a protocol error; flag it in a simulation assertion.
- Priority switch: if data_req rises while inst_req is pending and unaccepted, data wins the next cycle. The inst request keeps waiting (requesters hold stable).
- Latency:
  - Request path is 0 cycles, combinational pass-through when not full.
  - Return path is 0 cycles, combinational routing.
- Reset:
  - Pointers and count go to 0 (FIFO empty).
  - All outputs are 0 in the reset cycle, because outputs are gated by !reset.
  - Reset mid-operation drops outstanding tags. Downstream must also be reset the same cycle.

Decomposition:
- Shared header mycpu.h gets `SRC_INST 1'b0, `SRC_DATA 1'b1, and the like-SRAM size codes.
- One sub-module, tag_fifo: parameter DEPTH; ports push, push_tag, pop, head, full, empty.

Test Plan:
1. Single fetch: inst_req = 1, addr 0x1FC00000, mem_addr_ok in the same cycle → inst_addr_ok = 1. Two cycles later mem_data_ok with rdata 0x24010001 → inst_data_ok = 1, inst_rdata = 0x24010001, data_data_ok = 0.
2. Simultaneous requests: inst_req and data_req (load, addr 0x00001000) both high, mem_addr_ok = 1 → data_addr_ok = 1 and inst_addr_ok = 0. Next cycle the inst request is accepted. The two returns route data then inst, in order.
3. Full: DEPTH = 2, two accepted requests with no data_ok → mem_req = 0 with inst_req held. A mem_data_ok that cycle pops but mem_req stays 0. mem_req = 1 on the following cycle.
4. Store: data_wr = 1, wstrb 4'b0011, wdata 0xDEADBEEF → mem_* carries those values. The write completion raises data_data_ok.
5. Spurious return: mem_data_ok while empty → no data_ok on either side, count stays 0.
6. Reset mid-flight: two outstanding, assert reset for one cycle → count = 0, all outputs 0. A fresh fetch afterwards routes correctly.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants and types for the fetch/data like-SRAM request arbiter.
package sram_req_arbiter_pkg;

  // Owner tag stored per outstanding downstream transaction
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// Owner-tag FIFO: one bit per outstanding downstream transaction, popped in issue order.
module sram_req_arbiter_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PW = $clog2(DEPTH);

  logic          tag_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg, count_next;
  logic          push_ok, pop_ok;

  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = tag_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && wr_ptr_reg == PW'(gi)) tag_reg[gi] <= push_tag;
      end
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + (PW+1)'(1);
      2'b01:   count_next = count_reg - (PW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Merges fetch and data like-SRAM ports onto one in-order downstream port;
// a tag FIFO routes each completion back to its owner.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  logic     full, empty, head;
  logic     sel_data, sel_inst;
  logic     push, pop;
  mem_cmd_t cmd;

  assign sel_data = data_req;
  assign sel_inst = inst_req && !data_req;

  // Grant looks only at the registered count, so a same-cycle pop never
  // feeds mem_data_ok back into mem_req.
  assign mem_req = (data_req || inst_req) && !full && !reset;
  assign push    = mem_req && mem_addr_ok;
  assign pop     = mem_data_ok && !empty && !reset;

  always_comb begin
    cmd = '0;
    if (!reset) begin
      if (sel_data) begin
        cmd.wr    = data_wr;
        cmd.size  = data_size;
        cmd.wstrb = data_wstrb;
        cmd.addr  = data_addr;
        cmd.wdata = data_wdata;
      end else if (sel_inst) begin
        cmd.size  = inst_size;
        cmd.addr  = inst_addr;
      end
    end
  end

  assign mem_wr    = cmd.wr;
  assign mem_size  = cmd.size;
  assign mem_wstrb = cmd.wstrb;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  assign data_addr_ok = push && sel_data;
  assign inst_addr_ok = push && sel_inst;

  assign data_data_ok = pop && (head == SRC_DATA);
  assign inst_data_ok = pop && (head == SRC_INST);
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;

  sram_req_arbiter_tag_fifo #(
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_tag (sel_data ? SRC_DATA : SRC_INST),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

`ifndef SYNTHESIS
  // A completion with nothing outstanding is a downstream protocol error; it is dropped.
  assert property (@(posedge clk) disable iff (reset) !(mem_data_ok && empty))
    else $warning("sram_req_arbiter: mem_data_ok with no outstanding request ignored");
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Table-driven bench for sram_req_arbiter with a tag scoreboard for the return path.
module tb_sram_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  sram_req_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst, ireq, dreq, dwr, mao, mdo;
    logic [1:0]  dsize;
    logic [3:0]  wstrb;
    logic [31:0] iaddr, daddr, wdata, rdata;
    bit          e_req, e_iaok, e_daok;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit tag_q[$];
  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit ireq, bit dreq, bit mao, bit mdo,
                             logic [31:0] rdata, bit e_req, bit e_iaok, bit e_daok);
    vec_t t;
    t.rst = rst; t.ireq = ireq; t.dreq = dreq; t.dwr = 1'b0;
    t.mao = mao; t.mdo = mdo; t.rdata = rdata;
    t.dsize = 2'd2; t.wstrb = 4'h0;
    t.iaddr = 32'h1FC0_0000; t.daddr = 32'h0000_1000; t.wdata = 32'h0;
    t.e_req = e_req; t.e_iaok = e_iaok; t.e_daok = e_daok;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    bit tag, exp_i, exp_d;
    @(negedge clk);
    reset       = t.rst;
    inst_req    = t.ireq;
    inst_size   = 2'b10;
    inst_addr   = t.iaddr;
    data_req    = t.dreq;
    data_wr     = t.dwr;
    data_size   = t.dsize;
    data_wstrb  = t.wstrb;
    data_addr   = t.daddr;
    data_wdata  = t.wdata;
    mem_addr_ok = t.mao;
    mem_data_ok = t.mdo;
    mem_rdata   = t.rdata;
    #4;
    chk("mem_req", idx, 32'(mem_req), 32'(t.e_req));
    chk("inst_addr_ok", idx, 32'(inst_addr_ok), 32'(t.e_iaok));
    chk("data_addr_ok", idx, 32'(data_addr_ok), 32'(t.e_daok));
    if (t.rst) begin
      chk("rst_mem_addr", idx, mem_addr, 32'h0);
      chk("rst_mem_fields", idx, {25'h0, mem_wr, mem_size, mem_wstrb}, 32'h0);
      chk("rst_mem_wdata", idx, mem_wdata, 32'h0);
    end else if (t.e_req) begin
      chk("mem_addr", idx, mem_addr, t.dreq ? t.daddr : t.iaddr);
      chk("mem_wr", idx, 32'(mem_wr), t.dreq ? 32'(t.dwr) : 32'h0);
      chk("mem_size", idx, 32'(mem_size), t.dreq ? 32'(t.dsize) : 32'h2);
      chk("mem_wstrb", idx, 32'(mem_wstrb), t.dreq ? 32'(t.wstrb) : 32'h0);
      chk("mem_wdata", idx, mem_wdata, t.dreq ? t.wdata : 32'h0);
    end
    exp_i = 1'b0;
    exp_d = 1'b0;
    if (!t.rst && t.mdo && tag_q.size() > 0) begin
      tag = tag_q.pop_front();
      exp_d = tag;
      exp_i = !tag;
    end
    chk("inst_data_ok", idx, 32'(inst_data_ok), 32'(exp_i));
    chk("data_data_ok", idx, 32'(data_data_ok), 32'(exp_d));
    chk("inst_rdata", idx, inst_rdata, exp_i ? t.rdata : 32'h0);
    chk("data_rdata", idx, data_rdata, exp_d ? t.rdata : 32'h0);
    if (t.rst) tag_q.delete();
    else if (t.e_iaok) tag_q.push_back(1'b0);
    else if (t.e_daok) tag_q.push_back(1'b1);
    $display("step %0d: rst=%0b ireq=%0b dreq=%0b mem_req=%0b iaok=%0b daok=%0b idok=%0b ddok=%0b outstanding=%0d",
             idx, t.rst, t.ireq, t.dreq, mem_req, inst_addr_ok, data_addr_ok,
             inst_data_ok, data_data_ok, tag_q.size());
  endtask

  initial begin
    vec_t t;
    reset = 1'b1; inst_req = 1'b0; inst_size = 2'b10; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    //          rst ireq dreq mao mdo rdata         req iaok daok
    tbl.push_back(v(1, 1, 1, 1, 1, 32'h1234_5678, 0, 0, 0)); // reset: outputs gated
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0)); // single fetch
    tbl.push_back(v(0, 0, 0, 0, 0, 32'h0,         0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h2401_0001, 0, 0, 0)); // fetch return
    tbl.push_back(v(0, 1, 1, 1, 0, 32'h0,         1, 0, 1)); // data beats inst
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0)); // returns data, then inst
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h2222_2222, 0, 0, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0)); // fill to DEPTH
    tbl.push_back(v(0, 0, 1, 1, 0, 32'h0,         1, 0, 1));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, 0)); // full
    tbl.push_back(v(0, 1, 0, 1, 1, 32'h3333_3333, 0, 0, 0)); // pop does not unblock
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h4444_4444, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h5555_5555, 0, 0, 0));
    t = v(0, 0, 1, 1, 0, 32'h0, 1, 0, 1);                    // store
    t.dwr = 1'b1; t.wstrb = 4'b0011; t.wdata = 32'hDEAD_BEEF; t.daddr = 32'h0000_2000;
    tbl.push_back(t);
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h0,         0, 0, 0)); // write completion
    tbl.push_back(v(0, 0, 0, 0, 1, 32'hAAAA_AAAA, 0, 0, 0)); // spurious return
    tbl.push_back(v(0, 1, 0, 0, 0, 32'h0,         1, 0, 0)); // inst waiting
    tbl.push_back(v(0, 1, 1, 1, 0, 32'h0,         1, 0, 1)); // data rises, wins
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0));
    tbl.push_back(v(0, 1, 0, 1, 0, 32'h0,         0, 0, 0)); // full: count stayed 0 after spurious
    tbl.push_back(v(1, 1, 1, 1, 1, 32'h7777_0000, 0, 0, 0)); // reset mid-flight
    t = v(0, 1, 0, 1, 0, 32'h0, 1, 1, 0);
    t.iaddr = 32'h1FC0_0004;
    tbl.push_back(t);
    tbl.push_back(v(0, 0, 0, 0, 1, 32'h6666_6666, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 0, 1, 32'hBBBB_BBBB, 0, 0, 0)); // stale tags gone

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Same-cycle push and pop keeps the count steady
    apply(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0), 100);
    apply(v(0, 0, 1, 1, 1, 32'h7777_7777, 1, 0, 1), 101);
    apply(v(0, 1, 0, 1, 1, 32'h8888_8888, 1, 1, 0), 102);
    apply(v(0, 1, 0, 1, 0, 32'h0,         1, 1, 0), 103);
    apply(v(0, 0, 1, 1, 0, 32'h0,         0, 0, 0), 104);
    apply(v(0, 0, 0, 0, 1, 32'h9999_9999, 0, 0, 0), 105);
    apply(v(0, 0, 0, 0, 1, 32'hCCCC_CCCC, 0, 0, 0), 106);
    apply(v(0, 0, 0, 0, 1, 32'hDDDD_DDDD, 0, 0, 0), 107);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
